// File: rtl/id_exe_stage_reg_pkg.sv
// Shared encodings and field widths for the ID/EXE pipeline register.
package id_exe_stage_reg_pkg;

  localparam int REG_W   = 4;
  localparam int CMD_W   = 4;
  localparam int SHIFT_W = 12;
  localparam int SIMM_W  = 24;

  typedef enum logic [CMD_W-1:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // Control bits that must be killed by a bubble or an invalid instruction.
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
  localparam int TAG_W  = 3 * REG_W;

endpackage

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// One group of pipeline-register bits with hold (stall) and clear (bubble/squash).
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = d;
    if (hold)     q_d = q_q;
    else if (clr) q_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: bubble on load-use, squash on branch, hold on freeze,
// plus a saturating count of inserted bubbles.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               hazard,
  input  logic               id_valid,
  input  logic               id_wb_en,
  input  logic               id_mem_r_en,
  input  logic               id_mem_w_en,
  input  logic               id_b,
  input  logic               id_s,
  input  logic [3:0]         id_exe_cmd,
  input  logic               id_imm,
  input  logic [11:0]        id_shift_op,
  input  logic [23:0]        id_simm24,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_val_rn,
  input  logic [DATA_W-1:0]  id_val_rm,
  input  logic [3:0]         id_dest,
  input  logic [3:0]         id_src1,
  input  logic [3:0]         id_src2,
  input  logic               id_sr_c,
  output logic               exe_valid,
  output logic               exe_wb_en,
  output logic               exe_mem_r_en,
  output logic               exe_mem_w_en,
  output logic               exe_b,
  output logic               exe_s,
  output logic [3:0]         exe_exe_cmd,
  output logic               exe_imm,
  output logic [11:0]        exe_shift_op,
  output logic [23:0]        exe_simm24,
  output logic [DATA_W-1:0]  exe_pc,
  output logic [DATA_W-1:0]  exe_val_rn,
  output logic [DATA_W-1:0]  exe_val_rm,
  output logic [3:0]         exe_dest,
  output logic [3:0]         exe_src1,
  output logic [3:0]         exe_src2,
  output logic               exe_sr_c,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int DGRP_W = CMD_W + 1 + SHIFT_W + SIMM_W + 3 * DATA_W + 1;

  logic  clr;
  ctrl_t ctrl_d, ctrl_q;
  logic [DGRP_W-1:0] data_d, data_q;
  logic [TAG_W-1:0]  tag_d, tag_q;

  assign clr = flush | hazard;

  always_comb begin
    ctrl_d          = '0;
    ctrl_d.valid    = id_valid;
    ctrl_d.wb_en    = id_wb_en    & id_valid;
    ctrl_d.mem_r_en = id_mem_r_en & id_valid;
    ctrl_d.mem_w_en = id_mem_w_en & id_valid;
    ctrl_d.b        = id_b        & id_valid;
    ctrl_d.s        = id_s        & id_valid;
  end

  assign data_d = {id_exe_cmd, id_imm, id_shift_op, id_simm24,
                   id_pc, id_val_rn, id_val_rm, id_sr_c};
  assign tag_d  = {id_dest, id_src1, id_src2};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .hold(freeze), .clr(clr), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_field_reg #(.W(DGRP_W)) u_data (
    .clk(clk), .rst(rst), .hold(freeze), .clr(clr), .d(data_d), .q(data_q)
  );

  pipe_field_reg #(.W(TAG_W)) u_tag (
    .clk(clk), .rst(rst), .hold(freeze), .clr(clr), .d(tag_d), .q(tag_q)
  );

  assign exe_valid    = ctrl_q.valid;
  assign exe_wb_en    = ctrl_q.wb_en;
  assign exe_mem_r_en = ctrl_q.mem_r_en;
  assign exe_mem_w_en = ctrl_q.mem_w_en;
  assign exe_b        = ctrl_q.b;
  assign exe_s        = ctrl_q.s;

  assign {exe_exe_cmd, exe_imm, exe_shift_op, exe_simm24,
          exe_pc, exe_val_rn, exe_val_rm, exe_sr_c} = data_q;
  assign {exe_dest, exe_src1, exe_src2} = tag_q;

  // Only real instructions held back by a load-use stall count; a squash kills it anyway.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze && !flush && hazard && id_valid && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;

endmodule
